// File: rtl/vend_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_pkg : shared types and constants for the vending controller   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_PAYOUT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [6:0] NICKEL_CENTS  = 7'd5;
  localparam logic [6:0] DIME_CENTS    = 7'd10;
  localparam logic [6:0] QUARTER_CENTS = 7'd25;

  localparam int DEFAULT_PRICE0        = 15;
  localparam int DEFAULT_PRICE1        = 25;
  localparam int DEFAULT_PRICE2        = 35;
  localparam int DEFAULT_PRICE3        = 50;
  localparam int DEFAULT_MAX_CREDIT    = 95;
  localparam int DEFAULT_MOTOR_TIMEOUT = 255;

  // Amount left after paying out one coin (dime first, a lone nickel last).
  function automatic logic [6:0] pay_step(input logic [6:0] amt);
    pay_step = (amt >= DIME_CENTS) ? (amt - DIME_CENTS) : 7'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_controller_change_payout.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | change_payout : pays an amount out as one dime/nickel per cycle    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module change_payout
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] amount,
  input  logic       adv,
  output logic       ret_dime,
  output logic       ret_nickel,
  output logic       zero
);

  logic [6:0] amt_q, amt_d;
  logic [6:0] src;
  logic       ret_dime_q, ret_dime_d;
  logic       ret_nickel_q, ret_nickel_d;

  // The first coin is issued on the load itself so pulses line up with payout cycles.
  always_comb begin
    src          = load ? amount : amt_q;
    amt_d        = amt_q;
    ret_dime_d   = 1'b0;
    ret_nickel_d = 1'b0;
    if (load || adv) begin
      if (src >= DIME_CENTS) begin
        ret_dime_d = 1'b1;
      end else if (src == NICKEL_CENTS) begin
        ret_nickel_d = 1'b1;
      end
      amt_d = pay_step(src);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      amt_q        <= 7'd0;
      ret_dime_q   <= 1'b0;
      ret_nickel_q <= 1'b0;
    end else begin
      amt_q        <= amt_d;
      ret_dime_q   <= ret_dime_d;
      ret_nickel_q <= ret_nickel_d;
    end
  end

  assign ret_dime   = ret_dime_q;
  assign ret_nickel = ret_nickel_q;
  assign zero       = (amt_q == 7'd0);

endmodule
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vend_controller : credit, selection, motor handshake and payout    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE0        = DEFAULT_PRICE0,
  parameter int PRICE1        = DEFAULT_PRICE1,
  parameter int PRICE2        = DEFAULT_PRICE2,
  parameter int PRICE3        = DEFAULT_PRICE3,
  parameter int MAX_CREDIT    = DEFAULT_MAX_CREDIT,
  parameter int MOTOR_TIMEOUT = DEFAULT_MOTOR_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel,
  input  logic       dime,
  input  logic       quarter,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancel,
  input  logic       motor_ack,
  output logic       motor_req,
  output logic [1:0] motor_sel,
  output logic       ret_nickel,
  output logic       ret_dime,
  output logic       coin_reject,
  output logic       nsf,
  output logic       fault,
  output logic       done,
  output logic       busy,
  output logic [6:0] credit
);

  localparam logic [7:0] C_MAX_CREDIT = 8'(MAX_CREDIT);
  localparam logic [8:0] C_TIMEOUT    = 9'(MOTOR_TIMEOUT);

  state_t     state_q, state_d;
  logic [6:0] credit_q, credit_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] motor_sel_q, motor_sel_d;
  logic       motor_req_q, motor_req_d;
  logic       coin_reject_q, coin_reject_d;
  logic       nsf_q, nsf_d;
  logic       fault_q, fault_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  logic       pay_load, pay_adv, pay_zero;
  logic [6:0] pay_amount;

  logic [1:0] coin_cnt;
  logic       any_coin, coin_ok;
  logic [6:0] coin_val;
  logic [7:0] coin_sum;
  logic [6:0] sel_price, vend_price, refund;
  logic [8:0] cnt_next;
  logic       timeout_hit;

  function automatic logic [6:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 7'(PRICE0);
      2'd1:    price_of = 7'(PRICE1);
      2'd2:    price_of = 7'(PRICE2);
      default: price_of = 7'(PRICE3);
    endcase
  endfunction

  always_comb begin
    coin_cnt    = 2'(nickel) + 2'(dime) + 2'(quarter);
    any_coin    = (coin_cnt != 2'd0);
    coin_val    = quarter ? QUARTER_CENTS : (dime ? DIME_CENTS : (nickel ? NICKEL_CENTS : 7'd0));
    coin_sum    = {1'b0, credit_q} + {1'b0, coin_val};
    coin_ok     = (coin_cnt == 2'd1) && !sel_valid && !cancel && (coin_sum <= C_MAX_CREDIT);
    sel_price   = price_of(sel);
    vend_price  = price_of(motor_sel_q);
    refund      = credit_q + vend_price;
    cnt_next    = {1'b0, cnt_q} + 9'd1;
    timeout_hit = (cnt_next == C_TIMEOUT);
  end

  // Registered outputs are computed from the next state, so each pulse is
  // visible during the state it belongs to.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    cnt_d         = cnt_q;
    motor_sel_d   = motor_sel_q;
    motor_req_d   = 1'b0;
    coin_reject_d = 1'b0;
    nsf_d         = 1'b0;
    fault_d       = 1'b0;
    done_d        = 1'b0;
    pay_load      = 1'b0;
    pay_adv       = 1'b0;
    pay_amount    = credit_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          if (credit_q != 7'd0) begin
            state_d  = ST_PAYOUT;
            pay_load = 1'b1;
            credit_d = pay_step(credit_q);
          end
        end else if (sel_valid) begin
          if (credit_q >= sel_price) begin
            credit_d    = credit_q - sel_price;
            motor_sel_d = sel;
            cnt_d       = 8'd0;
            motor_req_d = 1'b1;
            state_d     = ST_VEND;
          end else begin
            nsf_d = 1'b1;
          end
        end
        if (any_coin) begin
          if (coin_ok) begin
            credit_d = coin_sum[6:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      ST_VEND: begin
        cnt_d = cnt_next[7:0];
        if (motor_ack) begin
          if (credit_q != 7'd0) begin
            state_d  = ST_PAYOUT;
            pay_load = 1'b1;
            credit_d = pay_step(credit_q);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else if (timeout_hit) begin
          fault_d    = 1'b1;
          state_d    = ST_PAYOUT;
          pay_load   = 1'b1;
          pay_amount = refund;
          credit_d   = pay_step(refund);
        end else begin
          motor_req_d = 1'b1;
        end
      end

      ST_PAYOUT: begin
        if (pay_zero) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          pay_adv  = 1'b1;
          credit_d = pay_step(credit_q);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_q != ST_IDLE) begin
      coin_reject_d = any_coin;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= 7'd0;
      cnt_q         <= 8'd0;
      motor_sel_q   <= 2'd0;
      motor_req_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      nsf_q         <= 1'b0;
      fault_q       <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      cnt_q         <= cnt_d;
      motor_sel_q   <= motor_sel_d;
      motor_req_q   <= motor_req_d;
      coin_reject_q <= coin_reject_d;
      nsf_q         <= nsf_d;
      fault_q       <= fault_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
    end
  end

  change_payout u_change_payout (
    .clk        (clk),
    .reset      (reset),
    .load       (pay_load),
    .amount     (pay_amount),
    .adv        (pay_adv),
    .ret_dime   (ret_dime),
    .ret_nickel (ret_nickel),
    .zero       (pay_zero)
  );

  assign motor_req   = motor_req_q;
  assign motor_sel   = motor_sel_q;
  assign coin_reject = coin_reject_q;
  assign nsf         = nsf_q;
  assign fault       = fault_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign credit      = credit_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vend_controller : directed and randomized checks of the vending |
// | controller against an arithmetic credit/change model. Rev 1.0      |
// +--------------------------------------------------------------------+
module tb_vend_controller;

  localparam int TO  = 20;
  localparam int MAX = 95;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       nickel = 1'b0, dime = 1'b0, quarter = 1'b0;
  logic       sel_valid = 1'b0, cancel = 1'b0, motor_ack = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       motor_req, ret_nickel, ret_dime, coin_reject, nsf, fault, done, busy;
  logic [1:0] motor_sel;
  logic [6:0] credit;

  int checks = 0;
  int errors = 0;
  int m_credit = 0;
  int prices[4] = '{15, 25, 35, 50};

  vend_controller #(
    .PRICE0(15), .PRICE1(25), .PRICE2(35), .PRICE3(50),
    .MAX_CREDIT(MAX), .MOTOR_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .motor_ack(motor_ack),
    .motor_req(motor_req), .motor_sel(motor_sel), .ret_nickel(ret_nickel),
    .ret_dime(ret_dime), .coin_reject(coin_reject), .nsf(nsf), .fault(fault),
    .done(done), .busy(busy), .credit(credit)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind: 0 nickel, 1 dime, 2 quarter, 3 nickel+dime together
  task automatic put(input int kind);
    int  v;
    bit  ok;
    v  = (kind == 0) ? 5 : (kind == 1) ? 10 : (kind == 2) ? 25 : 15;
    ok = (kind != 3) && (m_credit + v <= MAX);
    if (ok) m_credit += v;
    nickel  = (kind == 0 || kind == 3);
    dime    = (kind == 1 || kind == 3);
    quarter = (kind == 2);
    tick();
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
    chk("coin_credit", int'(credit), m_credit);
    chk("coin_reject", int'(coin_reject), ok ? 0 : 1);
  endtask

  // Samples from the current cycle (first payout cycle) until done.
  task automatic collect(input string tag, input int amt);
    int dimes = 0, nickels = 0, cycles = 0;
    bit got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      dimes   += int'(ret_dime);
      nickels += int'(ret_nickel);
      cycles++;
      tick();
    end
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_dimes"}, dimes, amt / 10);
    chk({tag, "_nickels"}, nickels, (amt % 10) / 5);
    chk({tag, "_cycles"}, cycles, (amt + 9) / 10);
    chk({tag, "_credit_at_done"}, int'(credit), 0);
    tick();
    chk({tag, "_idle_after"}, int'(busy), 0);
    chk({tag, "_done_one_cycle"}, int'(done), 0);
  endtask

  task automatic vend(input int s, input int ack_delay);
    int price;
    price     = prices[s];
    sel       = 2'(s);
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    if (m_credit < price) begin
      chk("nsf_pulse", int'(nsf), 1);
      chk("nsf_credit", int'(credit), m_credit);
      chk("nsf_busy", int'(busy), 0);
    end else begin
      chk("vend_req", int'(motor_req), 1);
      chk("vend_sel", int'(motor_sel), s);
      chk("vend_credit", int'(credit), m_credit - price);
      chk("vend_nsf", int'(nsf), 0);
      repeat (ack_delay) tick();
      motor_ack = 1'b1;
      tick();
      motor_ack = 1'b0;
      chk("ack_req_low", int'(motor_req), 0);
      collect("vend", m_credit - price);
      m_credit = 0;
    end
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    if (m_credit > 0) begin
      chk("cancel_busy", int'(busy), 1);
      collect("cancel", m_credit);
      m_credit = 0;
    end else begin
      chk("cancel_empty_busy", int'(busy), 0);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_motor_req", int'(motor_req), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ret", int'(ret_dime) + int'(ret_nickel), 0);
    reset = 1'b0;
    tick();

    // exact-price vend
    put(1); put(0);
    vend(0, 2);

    // vend with change: 60 - 35 = 25
    put(2); put(2); put(1);
    vend(2, 0);

    // insufficient funds, simultaneous coins
    put(2);
    vend(3, 0);
    put(3);
    chk("simul_credit", int'(credit), 25);
    do_cancel();

    // cap and cancel
    put(2); put(2); put(2); put(1); put(0);
    chk("cap_90", m_credit, 90);
    put(2);
    put(0);
    chk("cap_95", int'(credit), 95);
    do_cancel();

    // ack outside VEND is ignored
    motor_ack = 1'b1;
    tick();
    motor_ack = 1'b0;
    chk("stray_ack_busy", int'(busy), 0);

    // motor timeout with full refund
    put(1); put(1); put(1);
    sel = 2'd1; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    chk("to_req", int'(motor_req), 1);
    nickel = 1'b1;
    tick();
    nickel = 1'b0;
    chk("to_coin_reject", int'(coin_reject), 1);
    chk("to_coin_credit", int'(credit), 5);
    repeat (TO - 2) tick();
    chk("to_fault_early", int'(fault), 0);
    chk("to_req_held", int'(motor_req), 1);
    tick();
    chk("to_fault", int'(fault), 1);
    chk("to_req_low", int'(motor_req), 0);
    collect("timeout", 30);
    m_credit = 0;

    // reset during payout
    put(2); put(2);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("rp_first_dime", int'(ret_dime), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rp_credit", int'(credit), 0);
    chk("rp_busy", int'(busy), 0);
    chk("rp_ret", int'(ret_dime) + int'(ret_nickel), 0);
    chk("rp_done", int'(done), 0);
    m_credit = 0;
    put(0);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) put($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) do_cancel();
      else vend($urandom_range(0, 3), $urandom_range(0, 5));
    end
    do_cancel();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
